// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: tracks oversampling edges, steps through the
// frame fields and delivers a byte with parity/stop-bit status.
`timescale 1ns/1ps

// state   | meaning
// IDLE    | line idle, waiting for RX_IN low
// START   | start bit period, aborts on a high sample (false start)
// DATA    | eight data bit periods, LSB first into shift register
// PARITY  | parity bit period, evaluates par_err
// STOP    | stop bit, leaves at the sample so frames can run back to back
// DELIVER | one cycle, data_valid pulses here for a good frame
module uart_rx_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [5:0] Prescale,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic       sampled_bit,
  input  logic       smp_done,
  output logic [5:0] edge_cnt,
  output logic       smp_en,
  output logic [7:0] P_DATA,
  output logic       data_valid,
  output logic       par_err,
  output logic       stp_err
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, DELIVER
  } state_t;

  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic       par_en_r;
  logic       par_typ_r;
  logic       wrap;
  logic [5:0] edge_nxt;

  // >= rather than == so a Prescale reduction mid-frame cannot strand edge_cnt
  assign wrap     = (edge_cnt >= (Prescale - 6'd1));
  assign edge_nxt = wrap ? 6'd0 : edge_cnt + 6'd1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      edge_cnt   <= 6'd0;
      bit_cnt    <= 4'd0;
      smp_en     <= 1'b0;
      shreg      <= 8'h00;
      P_DATA     <= 8'h00;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      par_en_r   <= 1'b0;
      par_typ_r  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          edge_cnt <= 6'd0;
          bit_cnt  <= 4'd0;
          smp_en   <= 1'b0;
          if (!RX_IN) begin
            state     <= START;
            smp_en    <= 1'b1;
            par_err   <= 1'b0;
            stp_err   <= 1'b0;
            par_en_r  <= PAR_EN;
            par_typ_r <= PAR_TYP;
          end
        end
        START: begin
          edge_cnt <= edge_nxt;
          if (smp_done && sampled_bit) begin
            state    <= IDLE;
            smp_en   <= 1'b0;
            edge_cnt <= 6'd0;
          end else if (wrap) begin
            state   <= DATA;
            bit_cnt <= 4'd0;
          end
        end
        DATA: begin
          edge_cnt <= edge_nxt;
          if (smp_done)
            shreg <= {sampled_bit, shreg[7:1]};
          if (wrap) begin
            if (bit_cnt == 4'd7) begin
              bit_cnt <= 4'd0;
              state   <= par_en_r ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        PARITY: begin
          edge_cnt <= edge_nxt;
          if (smp_done)
            par_err <= (sampled_bit != ((^shreg) ^ par_typ_r));
          if (wrap)
            state <= STOP;
        end
        STOP: begin
          edge_cnt <= edge_nxt;
          if (smp_done) begin
            stp_err <= ~sampled_bit;
            state   <= DELIVER;
            if (sampled_bit && !par_err) begin
              P_DATA     <= shreg;
              data_valid <= 1'b1;
            end
          end else if (wrap) begin
            // no stop sample for a whole bit period: treat as a bad stop bit
            stp_err <= 1'b1;
            state   <= DELIVER;
          end
        end
        DELIVER: begin
          state    <= IDLE;
          smp_en   <= 1'b0;
          edge_cnt <= 6'd0;
        end
        default: begin
          state    <= IDLE;
          smp_en   <= 1'b0;
          edge_cnt <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: bit-level line driver, behavioural mid-bit sampler,
// and a frame-level model predicting bytes and error flags.
`timescale 1ns/1ps

module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       sampled_bit = 1'b0;
  logic       smp_done = 1'b0;
  logic [5:0] edge_cnt;
  logic       smp_en;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int         n_checks = 0;
  int         n_errors = 0;
  int         ps = 8;
  logic [7:0] last_good = 8'h00;
  logic [7:0] dv_q[$];

  always #5 CLK = ~CLK;

  uart_rx_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit),
    .smp_done(smp_done), .edge_cnt(edge_cnt), .smp_en(smp_en),
    .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err),
    .stp_err(stp_err)
  );

  // sampling stage stand-in: one strobe at mid-bit, taking the line value
  always @(posedge CLK) begin
    #1;
    if (smp_en === 1'b1 && edge_cnt == 6'(ps / 2)) begin
      smp_done    = 1'b1;
      sampled_bit = RX_IN;
    end else begin
      smp_done = 1'b0;
    end
  end

  always @(negedge CLK)
    if (data_valid === 1'b1) dv_q.push_back(P_DATA);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    RX_IN = b;
    repeat (n) @(negedge CLK);
  endtask

  // one frame on the line; a bad stop bit is a short low pulse so the line
  // is high again before the controller can look for the next start bit
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic bad_par, input logic stop_ok);
    int   n0;
    logic pbit;
    logic good;
    n0      = dv_q.size();
    PAR_EN  = pe;
    PAR_TYP = pt;
    drive_bit(1'b0, ps);
    PAR_EN  = 1'($urandom_range(0, 1));
    PAR_TYP = 1'($urandom_range(0, 1));
    for (int i = 0; i < 8; i++) drive_bit(d[i], ps);
    pbit = 1'($countones(d) % 2) ^ pt ^ bad_par;
    if (pe) drive_bit(pbit, ps);
    if (stop_ok) begin
      drive_bit(1'b1, ps);
    end else begin
      drive_bit(1'b0, ps / 2 + 1);
      drive_bit(1'b1, ps - ps / 2 - 1);
    end
    good = stop_ok && !(pe && bad_par);
    chk("dv_count", 32'(dv_q.size() - n0), good ? 32'd1 : 32'd0);
    if (good && dv_q.size() > n0) chk("rx_byte", 32'(dv_q[$]), 32'(d));
    if (good) last_good = d;
    chk("p_data", 32'(P_DATA), 32'(last_good));
    chk("par_err", 32'(par_err), 32'(pe && bad_par));
    chk("stp_err", 32'(stp_err), 32'(!stop_ok));
  endtask

  task automatic set_ps(input int p);
    ps       = p;
    Prescale = 6'(p);
  endtask

  initial begin
    int n0;
    int sel;
    logic [7:0] rb;

    repeat (3) @(negedge CLK);
    chk("rst_edge_cnt", 32'(edge_cnt), 32'd0);
    chk("rst_smp_en", 32'(smp_en), 32'd0);
    chk("rst_p_data", 32'(P_DATA), 32'd0);
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_par_err", 32'(par_err), 32'd0);
    chk("rst_stp_err", 32'(stp_err), 32'd0);
    RST = 1'b1;
    repeat (3) @(negedge CLK);

    set_ps(8);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);

    // false start: two low cycles then high
    n0 = dv_q.size();
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 4 * ps);
    chk("fs_dv_count", 32'(dv_q.size() - n0), 32'd0);
    chk("fs_p_data", 32'(P_DATA), 32'hA5);
    chk("fs_par_err", 32'(par_err), 32'd0);
    chk("fs_stp_err", 32'(stp_err), 32'd0);
    chk("fs_smp_en", 32'(smp_en), 32'd0);

    set_ps(16);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);

    set_ps(32);
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);

    set_ps(16);
    drive_bit(1'b1, 5);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);

    // reset in the middle of data bit 4
    set_ps(8);
    PAR_EN = 1'b0;
    rb = 8'hC3;
    drive_bit(1'b0, ps);
    for (int i = 0; i < 4; i++) drive_bit(rb[i], ps);
    drive_bit(rb[4], ps / 2);
    RST = 1'b0;
    #1;
    chk("mr_edge_cnt", 32'(edge_cnt), 32'd0);
    chk("mr_smp_en", 32'(smp_en), 32'd0);
    chk("mr_p_data", 32'(P_DATA), 32'd0);
    chk("mr_dv", 32'(data_valid), 32'd0);
    chk("mr_par_err", 32'(par_err), 32'd0);
    chk("mr_stp_err", 32'(stp_err), 32'd0);
    RX_IN = 1'b1;
    @(negedge CLK);
    chk("mr_hold_smp_en", 32'(smp_en), 32'd0);
    @(negedge CLK);
    last_good = 8'h00;
    RST = 1'b1;
    repeat (5) @(negedge CLK);
    chk("mr_idle_edge_cnt", 32'(edge_cnt), 32'd0);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 20; k++) begin
      sel = int'($urandom_range(0, 2));
      set_ps(sel == 0 ? 8 : (sel == 1 ? 16 : 32));
      drive_bit(1'b1, int'($urandom_range(0, 3)));
      send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) != 0));
    end

    // Prescale shrinks mid-frame: controller must still find its way to IDLE
    set_ps(32);
    PAR_EN = 1'b1;
    drive_bit(1'b0, 3 * 32 + int'($urandom_range(0, 31)));
    set_ps(8);
    drive_bit(1'b1, 12 * 32);
    chk("psc_smp_en", 32'(smp_en), 32'd0);
    chk("psc_edge_cnt", 32'(edge_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
